alu_op_issuer: RTL

Issue side of the ALU output selection interface. Accepts an operation request (opcode plus two 16-bit operands) over a valid/ready handshake and holds the operands stable to the ALU datapath. It drives exactly one of the eight mixed-polarity operation-select lines into the output mux for a fixed settle window, then captures Result/notResult. Returns the registered result with zero and integrity flags over a second valid/ready handshake.

---
 rtl/alu_op_issuer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// Issue side of the ALU output-select interface: accepts an op, drives one select
// line for a fixed settle window, captures Result/notResult and returns it.
module alu_op_issuer #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [2:0]  ReqOp,
  input  logic [15:0] ReqA,
  input  logic [15:0] ReqB,
  output logic [15:0] OperandA,
  output logic [15:0] OperandB,
  output logic        notPAs_ADD,
  output logic        notPAs_AND,
  output logic        PA_OR,
  output logic        PA_XOR,
  output logic        notPAs_RL,
  output logic        notPAs_RR,
  output logic        PA_RLD,
  output logic        PA_RRD,
  input  logic [15:0] Result,
  input  logic [15:0] notResult,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [15:0] RspData,
  output logic        RspZero,
  output logic        RspError,
  output logic [1:0]  dbg_state
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Select bus order {RRD,RLD,RR,RL,XOR,OR,AND,ADD}, stored at pin polarity so
  // the pins come straight off flops; the idle pattern is every line inactive.
  localparam logic [7:0] SEL_IDLE = 8'b0011_0011;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sel_q, sel_d;
  logic        narrow_q, narrow_d;
  logic        ready_q, ready_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;

  // Handshakes: a request transfers on a CLK edge with ReqValid&ReqReady, a
  // response transfers on a CLK edge with RspValid&RspReady; both ready/valid
  // outputs are registered and never depend on the same-cycle input.
  logic accept, done, consume;
  logic [15:0] cap_data;

  assign accept   = (state_q == IDLE) && ReqValid;
  assign done     = (state_q == DRIVE) && (cnt_q == 4'd0);
  assign consume  = (state_q == RESP) && RspReady;
  assign cap_data = narrow_q ? {8'h00, Result[7:0]} : Result;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sel_q       <= SEL_IDLE;
      narrow_q    <= 1'b0;
      ready_q     <= 1'b1;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      narrow_q    <= narrow_d;
      ready_q     <= ready_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = DRIVE;
      DRIVE:   if (done)    state_d = RESP;
      RESP:    if (consume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every output register; applied by the register process.
  always_comb begin
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    narrow_d    = narrow_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      opa_d    = ReqA;
      opb_d    = ReqB;
      cnt_d    = CNT_LOAD;
      sel_d    = SEL_IDLE ^ (8'b0000_0001 << ReqOp);
      narrow_d = (ReqOp >= 3'd1) && (ReqOp <= 3'd5);
    end
    if ((state_q == DRIVE) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (done) begin
      sel_d       = SEL_IDLE;
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_data;
      rsp_zero_d  = (cap_data == 16'h0000);
      rsp_err_d   = ((Result ^ notResult) != 16'hFFFF);
    end
    if (consume) begin
      rsp_valid_d = 1'b0;
    end
    ready_d = (state_d == IDLE);
  end

  assign ReqReady   = ready_q;
  assign OperandA   = opa_q;
  assign OperandB   = opb_q;
  assign notPAs_ADD = sel_q[0];
  assign notPAs_AND = sel_q[1];
  assign PA_OR      = sel_q[2];
  assign PA_XOR     = sel_q[3];
  assign notPAs_RL  = sel_q[4];
  assign notPAs_RR  = sel_q[5];
  assign PA_RLD     = sel_q[6];
  assign PA_RRD     = sel_q[7];
  assign RspValid   = rsp_valid_q;
  assign RspData    = rsp_data_q;
  assign RspZero    = rsp_zero_q;
  assign RspError   = rsp_err_q;
  assign dbg_state  = state_q;

endmodule
